// File: rtl/rv_pipe_ctrl.sv
// rv_pipe_ctrl: pipeline hazard controller for the uRV core.
// Merges per-stage stall requests, the taken-branch kill shadow and a
// load-use interlock into per-stage stall/kill vectors plus a bubble strobe,
// and keeps four saturating hazard event counters for profiling.
module rv_pipe_ctrl #(
    parameter int g_num_stages     = 4,
    parameter int g_x_stage        = 2,
    parameter int g_load_use_stall = 1,
    parameter int g_w_stall_en     = 0,
    parameter int g_cnt_width      = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [g_num_stages-1:0] stall_req_i,
    input  logic                    branch_take_i,
    input  logic                    load_hazard_i,
    output logic [g_num_stages-1:0] stall_o,
    output logic [g_num_stages-1:0] kill_o,
    output logic                    bubble_o,
    input  logic [1:0]              cnt_sel_i,
    input  logic                    cnt_clear_i,
    output logic [g_cnt_width-1:0]  cnt_o
);

    localparam int N  = g_num_stages;
    localparam int X  = g_x_stage;
    localparam int L  = g_load_use_stall;
    localparam int CW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_GUARD} ilk_state_t;

    ilk_state_t             ilk_state;
    logic [CW-1:0]          ilk_cnt;
    logic [X-1:0]           bra_d;
    logic [N-1:0]           base_stall;
    logic [N-1:0]           stall_raw;
    logic [N-1:0]           kill_raw;
    logic                   stall_x;
    logic                   start;
    logic                   ilk_active;
    logic [3:0]             ev;
    logic [g_cnt_width-1:0] ev_cnt [4];

    function automatic logic [g_cnt_width-1:0] sat_inc(input logic [g_cnt_width-1:0] v,
                                                       input logic inc);
        return (inc && (v != '1)) ? v + g_cnt_width'(1) : v;
    endfunction

    // Combinational hazard resolution; every output is forced low while in reset.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            base_stall[k] = |(stall_req_i >> k);
        end
        stall_x = base_stall[X];

        for (int k = 0; k < N; k++) begin
            kill_raw[k] = 1'b0;
            if (k <= X) begin
                kill_raw[k] = branch_take_i;
                for (int j = 0; j < X; j++) begin
                    if (j < k) kill_raw[k] = kill_raw[k] | bra_d[j];
                end
            end
        end

        // A branch wins over a new hazard and aborts an interlock in progress.
        start = rst_n_i && load_hazard_i && (ilk_state == ST_IDLE) && !kill_raw[X-1]
                && !stall_x && !branch_take_i && (L > 0);
        ilk_active = start || ((ilk_state == ST_ACTIVE) && !branch_take_i);

        for (int k = 0; k < N; k++) begin
            stall_raw[k] = base_stall[k] | (ilk_active && (k < X));
        end
        if (g_w_stall_en == 0) stall_raw[N-1] = 1'b0;

        stall_o  = rst_n_i ? stall_raw : '0;
        kill_o   = rst_n_i ? kill_raw : '0;
        bubble_o = rst_n_i && ilk_active && !stall_x;

        ev[0] = stall_o[0];
        ev[1] = kill_o[0];
        ev[2] = rst_n_i && branch_take_i && !stall_x;
        ev[3] = start;
    end

    // Branch shadow shift register; frozen while the resolving stage is held.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bra_d <= '0;
        end else if (!stall_x) begin
            bra_d[0] <= branch_take_i;
            for (int i = 1; i < X; i++) bra_d[i] <= bra_d[i-1];
        end
    end

    // Load-use interlock: bubbles counted down on unstalled cycles, then a guard cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ilk_state <= ST_IDLE;
            ilk_cnt   <= '0;
        end else begin
            case (ilk_state)
                ST_IDLE: begin
                    if (start) begin
                        if (L == 1) begin
                            ilk_state <= ST_GUARD;
                        end else begin
                            ilk_state <= ST_ACTIVE;
                            ilk_cnt   <= CW'(L - 1);
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (branch_take_i) begin
                        ilk_state <= ST_IDLE;
                    end else if (!stall_x) begin
                        if (ilk_cnt == CW'(1)) ilk_state <= ST_GUARD;
                        else                   ilk_cnt   <= ilk_cnt - CW'(1);
                    end
                end
                ST_GUARD: ilk_state <= ST_IDLE;
                default:  ilk_state <= ST_IDLE;
            endcase
        end
    end

    // Saturating event counters with clear priority, plus the registered readout.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < 4; c++) ev_cnt[c] <= '0;
            cnt_o <= '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                ev_cnt[c] <= cnt_clear_i ? '0 : sat_inc(ev_cnt[c], ev[c]);
            end
            cnt_o <= ev_cnt[cnt_sel_i];
        end
    end

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Scoreboard bench for rv_pipe_ctrl: two instances (default config, and a
// 3-bubble / last-stage-stallable / 4-bit-counter config) share stimulus.
module tb_rv_pipe_ctrl;

    localparam int N = 4;
    localparam int X = 2;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [3:0]  stall_req_i;
    logic        branch_take_i;
    logic        load_hazard_i;
    logic [1:0]  cnt_sel_i;
    logic        cnt_clear_i;
    logic [3:0]  stall_a, kill_a, stall_b, kill_b;
    logic        bub_a, bub_b;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;

    always #5 clk_i = ~clk_i;

    rv_pipe_ctrl #(.g_num_stages(4), .g_x_stage(2), .g_load_use_stall(1),
                   .g_w_stall_en(0), .g_cnt_width(32)) u_a (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_req_i(stall_req_i),
        .branch_take_i(branch_take_i), .load_hazard_i(load_hazard_i),
        .stall_o(stall_a), .kill_o(kill_a), .bubble_o(bub_a),
        .cnt_sel_i(cnt_sel_i), .cnt_clear_i(cnt_clear_i), .cnt_o(cnt_a));

    rv_pipe_ctrl #(.g_num_stages(4), .g_x_stage(2), .g_load_use_stall(3),
                   .g_w_stall_en(1), .g_cnt_width(4)) u_b (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_req_i(stall_req_i),
        .branch_take_i(branch_take_i), .load_hazard_i(load_hazard_i),
        .stall_o(stall_b), .kill_o(kill_b), .bubble_o(bub_b),
        .cnt_sel_i(cnt_sel_i), .cnt_clear_i(cnt_clear_i), .cnt_o(cnt_b));

    typedef struct packed {
        logic [3:0]  stall;
        logic [3:0]  kill;
        logic        bub;
        logic [31:0] cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model state, per instance
    int     P_L [2] = '{1, 3};
    bit     P_W [2] = '{1'b0, 1'b1};
    int     P_CW[2] = '{32, 4};
    int     m_age  [2];    // advances since youngest in-flight branch, -1 if none
    int     m_rem  [2];    // interlock bubbles still owed after the starting cycle
    bit     m_guard[2];
    longint m_ctr  [2][4];
    longint m_cnt_reg[2];

    task automatic model_step(input int i, output exp_t e);
        bit     stall_x, kill_xm1, idle, start, active, base;
        bit     ev[4];
        int     old_rem;
        bit     old_guard;
        longint maxv;
        e = '0;
        if (!rst_n_i) begin
            m_age[i] = -1; m_rem[i] = 0; m_guard[i] = 0; m_cnt_reg[i] = 0;
            for (int c = 0; c < 4; c++) m_ctr[i][c] = 0;
            return;
        end
        stall_x  = (stall_req_i >> X) != 0;
        kill_xm1 = branch_take_i || (m_age[i] >= 0 && m_age[i] < X - 1);
        idle     = (m_rem[i] == 0) && !m_guard[i];
        start    = load_hazard_i && idle && !kill_xm1 && !stall_x && !branch_take_i && (P_L[i] > 0);
        active   = start || (m_rem[i] > 0 && !branch_take_i);
        for (int k = 0; k < N; k++) begin
            base = (stall_req_i >> k) != 0;
            e.stall[k] = base || (active && k < X);
            if (k == N - 1 && !P_W[i]) e.stall[k] = 1'b0;
            e.kill[k] = (k <= X) && (branch_take_i || (m_age[i] >= 0 && k > m_age[i]));
        end
        e.bub = active && !stall_x;
        e.cnt = 32'(m_cnt_reg[i]);

        ev[0] = e.stall[0];
        ev[1] = e.kill[0];
        ev[2] = branch_take_i && !stall_x;
        ev[3] = start;
        maxv  = (longint'(1) << P_CW[i]) - 1;
        m_cnt_reg[i] = m_ctr[i][cnt_sel_i];
        for (int c = 0; c < 4; c++) begin
            if (cnt_clear_i)                    m_ctr[i][c] = 0;
            else if (ev[c] && m_ctr[i][c] < maxv) m_ctr[i][c] = m_ctr[i][c] + 1;
        end

        old_rem   = m_rem[i];
        old_guard = m_guard[i];
        if (start) begin
            m_rem[i]   = P_L[i] - 1;
            m_guard[i] = (P_L[i] == 1);
        end else if (old_rem > 0) begin
            if (branch_take_i) m_rem[i] = 0;
            else if (!stall_x) begin
                m_rem[i] = old_rem - 1;
                if (m_rem[i] == 0) m_guard[i] = 1'b1;
            end
        end else if (old_guard) begin
            m_guard[i] = 1'b0;
        end

        if (!stall_x) begin
            if (branch_take_i) m_age[i] = 0;
            else if (m_age[i] >= 0) begin
                m_age[i] = m_age[i] + 1;
                if (m_age[i] >= X) m_age[i] = -1;
            end
        end
    endtask

    task automatic drive(input bit rst, input logic [3:0] sreq, input bit bra,
                         input bit hz, input logic [1:0] sel, input bit clr);
        exp_t ea, eb;
        @(posedge clk_i);
        #1;
        rst_n_i = rst; stall_req_i = sreq; branch_take_i = bra;
        load_hazard_i = hz; cnt_sel_i = sel; cnt_clear_i = clr;
        model_step(0, ea);
        model_step(1, eb);
        qa.push_back(ea);
        qb.push_back(eb);
        cyc++;
    endtask

    // Monitor: pops one expectation per instance each cycle, mid-cycle
    exp_t ma, mb;
    always @(negedge clk_i) begin
        if (qa.size() > 0) begin
            ma = qa.pop_front();
            n_tests++;
            if ({stall_a, kill_a, bub_a, cnt_a} !== {ma.stall, ma.kill, ma.bub, ma.cnt}) begin
                n_fail++;
                $display("FAIL dut_a cyc=%0d got stall=%b kill=%b bub=%b cnt=%0d exp stall=%b kill=%b bub=%b cnt=%0d",
                         cyc, stall_a, kill_a, bub_a, cnt_a, ma.stall, ma.kill, ma.bub, ma.cnt);
            end
        end
        if (qb.size() > 0) begin
            mb = qb.pop_front();
            n_tests++;
            if ({stall_b, kill_b, bub_b, {28'd0, cnt_b}} !== {mb.stall, mb.kill, mb.bub, mb.cnt}) begin
                n_fail++;
                $display("FAIL dut_b cyc=%0d got stall=%b kill=%b bub=%b cnt=%0d exp stall=%b kill=%b bub=%b cnt=%0d",
                         cyc, stall_b, kill_b, bub_b, cnt_b, mb.stall, mb.kill, mb.bub, mb.cnt);
            end
        end
    end

    logic [1:0] r_sel;
    bit         r_hz;
    bit         r_rst;
    int         rst_left;

    initial begin
        rst_n_i = 1'b0; stall_req_i = '0; branch_take_i = 1'b0;
        load_hazard_i = 1'b0; cnt_sel_i = '0; cnt_clear_i = 1'b0;

        // Reset held with all inputs toggling
        for (int i = 0; i < 6; i++)
            drive(0, 4'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
        repeat (2) drive(1, 4'b0000, 0, 0, 2'd2, 0);

        // Single-cycle branch, shadow decays; read branch then kill counters
        drive(1, 4'b0000, 1, 0, 2'd2, 0);
        repeat (3) drive(1, 4'b0000, 0, 0, 2'd2, 0);
        repeat (2) drive(1, 4'b0000, 0, 0, 2'd1, 0);

        // Branch followed by a last-stage stall freezing the shadow
        drive(1, 4'b0000, 1, 0, 2'd0, 0);
        repeat (3) drive(1, 4'b1000, 0, 0, 2'd0, 0);
        repeat (4) drive(1, 4'b0000, 0, 0, 2'd3, 0);

        // Load hazard held two cycles, then the guard cycle
        repeat (2) drive(1, 4'b0000, 0, 1, 2'd3, 0);
        repeat (4) drive(1, 4'b0000, 0, 0, 2'd3, 0);

        // Branch and hazard together; then branch during an active interlock
        drive(1, 4'b0000, 1, 1, 2'd3, 0);
        repeat (3) drive(1, 4'b0000, 0, 0, 2'd3, 0);
        drive(1, 4'b0000, 0, 1, 2'd3, 0);
        drive(1, 4'b0000, 1, 1, 2'd3, 0);
        repeat (3) drive(1, 4'b0000, 0, 0, 2'd3, 0);

        // Reset asserted in the middle of an interlock
        drive(1, 4'b0000, 0, 1, 2'd3, 0);
        drive(0, 4'b0000, 0, 1, 2'd3, 0);
        drive(1, 4'b0000, 0, 1, 2'd3, 0);
        repeat (4) drive(1, 4'b0000, 0, 0, 2'd3, 0);

        // Stall counter saturation, then clear together with a stall
        repeat (20) drive(1, 4'b0001, 0, 0, 2'd0, 0);
        drive(1, 4'b0001, 0, 0, 2'd0, 1);
        repeat (3) drive(1, 4'b0000, 0, 0, 2'd0, 0);

        // Randomized traffic with occasional reset pulses and clears
        r_sel = 2'd0; r_hz = 1'b0; rst_left = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] sreq;
            for (int k = 0; k < N; k++) sreq[k] = ($urandom_range(9) == 0);
            if ($urandom_range(9) == 0) r_sel = 2'($urandom);
            if ($urandom_range(3) == 0) r_hz = ~r_hz;
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(299) == 0) rst_left = $urandom_range(3, 1);
            r_rst = (rst_left == 0);
            drive(r_rst, sreq, ($urandom_range(7) == 0), r_hz, r_sel, ($urandom_range(63) == 0));
        end
        repeat (2) drive(1, 4'b0000, 0, 0, 2'd0, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 10 && (qa.size() > 0 || qb.size() > 0); w++) @(negedge clk_i);
        @(posedge clk_i);
        n_tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL drain got pending=%0d exp pending=0", qa.size() + qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
